// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage external SRAM path.
// Holds the controller state encoding, the SRAM data width, the default
// half-word address width, the byte address mapped to SRAM word 0 and the
// default number of cycles per 16-bit phase.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam int SRAM_DW             = 16;
    localparam int DEFAULT_ADDR_W      = 18;
    localparam int SRAM_BASE_ADDR      = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 5;

endpackage

// File: rtl/sram_phase_timer.sv
// Per-phase cycle timer for the SRAM controller.
// A down-counter reloaded with WAIT_CYCLES-1 when a phase is entered; it then
// counts down to 0 and parks there until the next reload.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   load   in  reload request, asserted in the cycle before a phase starts
//   first  out current cycle is the first cycle of the phase
//   last   out current cycle is the last cycle of the phase
module sram_phase_timer
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic first,
    output logic last
);

    localparam int CW = $clog2(WAIT_CYCLES);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= CW'(WAIT_CYCLES - 1);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign first = (r_count == CW'(WAIT_CYCLES - 1));
    assign last  = (r_count == '0);

endmodule

// File: rtl/sram_controller.sv
// Sequences MEM-stage 32-bit loads/stores onto a 16-bit asynchronous SRAM as
// two timed half-word phases (low half first, then high half).
//
// Handshake: wr_en/rd_en are level requests that the pipeline holds while
// ready is 0; ready = ~(wr_en|rd_en) | DONE, so a request drops ready in the
// same cycle it appears and ready rises only in the DONE cycle, on whose
// closing edge the pipeline samples read_data and moves on.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   wr_en, rd_en               store / load request (write wins if both)
//   address, write_data        byte address and store data
//   read_data                  registered load result
//   ready                      0 = access in progress, freeze the pipeline
//   sram_dq                    bidirectional SRAM data bus
//   sram_addr                  SRAM half-word address {word, phase}
//   sram_*_n                   active-low SRAM strobes
//   dbg                        {timer first, dq driven, state[1:0]}
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    output logic                ready,
    inout  wire  [SRAM_DW-1:0]  sram_dq,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic                sram_ce_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n,
    output logic [3:0]          dbg
);

    sram_state_e        r_state;
    sram_state_e        w_next;
    logic               r_is_write;
    logic [ADDR_W-2:0]  r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;
    logic [ADDR_W-2:0]  w_word;
    logic               w_first;
    logic               w_last;
    logic               w_load;
    logic               w_in_phase;
    logic               w_high;
    logic               w_dq_oe;
    logic [SRAM_DW-1:0] w_dq_out;

    // Offset from the base, divided into words; the cast truncates, so
    // addresses below the base wrap around the top of the SRAM.
    assign w_word = (ADDR_W-1)'((address - 32'(BASE_ADDR)) >> 2);

    sram_phase_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .first (w_first),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_phase = 1'b0;
        w_high     = 1'b0;
        case (r_state)
            ST_IDLE: if (wr_en || rd_en) w_next = ST_LOW;
            ST_LOW: begin
                w_in_phase = 1'b1;
                if (w_last) w_next = ST_HIGH;
            end
            ST_HIGH: begin
                w_in_phase = 1'b1;
                w_high     = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase

        // Strobes decode straight from the state so an asynchronous reset
        // releases the SRAM without waiting for a clock edge.
        sram_ce_n = ~w_in_phase;
        sram_ub_n = ~w_in_phase;
        sram_lb_n = ~w_in_phase;
        sram_oe_n = ~(w_in_phase && !r_is_write);
        // we_n returns high on the last phase cycle so address and data are
        // held past the write pulse.
        sram_we_n = ~(w_in_phase && r_is_write && !w_last);
        w_dq_oe   = w_in_phase && r_is_write;
        w_dq_out  = w_high ? r_wdata[31:16] : r_wdata[15:0];
        sram_addr = {r_word, w_high};
        ready     = ~(wr_en | rd_en) | (r_state == ST_DONE);
    end

    // Reload the timer on entry to either phase.
    assign w_load = (w_next != r_state) && ((w_next == ST_LOW) || (w_next == ST_HIGH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_write <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
        end else if ((r_state == ST_IDLE) && (wr_en || rd_en)) begin
            r_is_write <= wr_en;
            r_word     <= w_word;
            r_wdata    <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_read_data <= '0;
        end else if (w_in_phase && !r_is_write && w_last) begin
            if (w_high) begin
                r_read_data[31:16] <= sram_dq;
            end else begin
                r_read_data[15:0] <= sram_dq;
            end
        end
    end

    assign sram_dq   = w_dq_oe ? w_dq_out : 'z;
    assign read_data = r_read_data;
    assign dbg       = {w_first, w_dq_oe, r_state};

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed vector table, hand-written reset
// sequence and randomized accesses against a word-level reference memory.
module tb_sram_controller;
    import arm_mem_pkg::*;

    localparam int WC = 5;
    localparam int AW = 18;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    wire  [15:0]   sram_dq;
    logic [AW-1:0] sram_addr;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic          sram_ce_n;
    logic          sram_ub_n;
    logic          sram_lb_n;
    logic [3:0]    dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [15:0] sram_mem [0:(1<<AW)-1];
    logic [31:0] ref_words [int];
    int          written_q[$];

    sram_controller #(
        .ADDR_W      (AW),
        .WAIT_CYCLES (WC),
        .BASE_ADDR   (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_dq    (sram_dq),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n),
        .dbg        (dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 'z;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] = sram_dq;
    end

    // ---------------- checker ----------------
    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge with the DUT in IDLE. Holds the request
    // for the whole access and checks every cycle against the timing rules.
    task automatic access(input logic w, input logic r, input logic [31:0] addr,
                          input logic [31:0] data, input logic [AW-1:0] exp_lo);
        logic [31:0] exp_rd;
        exp_rd     = exp_q.pop_front();
        wr_en      = w;
        rd_en      = r;
        address    = addr;
        write_data = data;
        for (int c = 0; c <= 2*WC+1; c++) begin
            int   k;
            logic in_ph;
            logic hi;
            @(negedge clk);
            in_ph = (c >= 1) && (c <= 2*WC);
            hi    = (c > WC);
            k     = in_ph ? ((c - 1) % WC) + 1 : 0;
            check("ready", {31'd0, ready}, {31'd0, c == 2*WC+1});
            check("ce_n", {31'd0, sram_ce_n}, {31'd0, !in_ph});
            check("ub_n", {31'd0, sram_ub_n}, {31'd0, !in_ph});
            check("lb_n", {31'd0, sram_lb_n}, {31'd0, !in_ph});
            check("oe_n", {31'd0, sram_oe_n}, {31'd0, !(in_ph && !w)});
            check("we_n", {31'd0, sram_we_n}, {31'd0, !(in_ph && w && k != WC)});
            check("dq_driven", {31'd0, dbg[2]}, {31'd0, in_ph && w});
            if (in_ph) check("sram_addr", 32'(sram_addr), 32'(exp_lo | AW'(hi)));
            if (in_ph && w) check("dq", {16'd0, sram_dq}, {16'd0, hi ? data[31:16] : data[15:0]});
            if (c == 0) check("gap_state", {30'd0, dbg[1:0]}, {30'd0, ST_IDLE});
            if (c == 2*WC+1) check("read_data", read_data, exp_rd);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", {31'd0, ready}, 32'd1);
            check("idle_ce_n", {31'd0, sram_ce_n}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          wr;
        logic          rd;
        logic          b2b;
        logic [31:0]   addr;
        logic [31:0]   data;
        logic [AW-1:0] exp_lo;
        logic [31:0]   exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] last_rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] wd;
        int          idx;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,       32'h12345678};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 32'd1032, 32'hDEADBEEF, 18'd4,       32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'h0,        18'd4,       32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'd1036, 32'h0000FFFF, 18'd6,       32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'd1036, 32'h0,        18'd6,       32'h0000FFFF};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'd1020, 32'hCAFEF00D, 18'h3FFFE,   32'h0000FFFF};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 32'd1020, 32'h0,        18'h3FFFE,   32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'hA5A5A5A5, 18'd0,       32'hCAFEF00D};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,        18'd0,       32'hA5A5A5A5};

        sram_mem[4] = 16'h5678;
        sram_mem[5] = 16'h1234;

        rst        = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_strobes", {27'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_state", {28'd0, dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(vecs[i].exp_rd);
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].exp_lo);
            if (!vecs[i].b2b) idle(2);
        end
        last_rd = 32'hA5A5A5A5;

        // Randomized accesses against a word-level reference memory
        for (int n = 0; n < 40; n++) begin
            if (written_q.size() == 0 || $urandom_range(0, 1) == 0) begin
                idx = int'($urandom_range(0, 31));
                a   = 32'd2048 + 32'(idx * 4) + 32'($urandom_range(0, 3));
                d   = $urandom;
                wd  = (a - 32'd1024) >> 2;
                ref_words[int'(wd)] = d;
                written_q.push_back(int'(wd));
                exp_q.push_back(last_rd);
                access(1'b1, 1'b0, a, d, {wd[AW-2:0], 1'b0});
            end else begin
                wd = 32'(written_q[$urandom_range(0, written_q.size() - 1)]);
                a  = 32'd1024 + (wd << 2) + 32'($urandom_range(0, 3));
                last_rd = ref_words[int'(wd)];
                exp_q.push_back(last_rd);
                access(1'b0, 1'b1, a, 32'h0, {wd[AW-2:0], 1'b0});
            end
            idle(int'($urandom_range(0, 2)));
        end

        // Reset during the second cycle of the high phase of a write
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = 32'd1040;
        write_data = 32'h11112222;
        repeat (7) @(posedge clk);
        #2;
        check("pre_rst_state", {30'd0, dbg[1:0]}, {30'd0, ST_HIGH});
        check("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_strobes", {27'd0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("mid_rst_dq_driven", {31'd0, dbg[2]}, 32'd0);
        check("mid_rst_state", {30'd0, dbg[1:0]}, {30'd0, ST_IDLE});
        check("mid_rst_read_data", read_data, 32'd0);
        check("mid_rst_addr", 32'(sram_addr), 32'd0);
        wr_en = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Normal operation after the aborted write
        exp_q.push_back(32'hA5A5A5A5);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0);
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
